pixel_frame_store: RTL and testbench
====================================

Name: pixel_frame_store

Overview:
Receiving end of the pixel-draw interface (x, y, colour, writeEn) that the card and symbol drawers drive. Stores each accepted pixel in an on-chip 160x120x3 frame memory. Replays the whole frame on request as a raster-ordered valid/ready pixel stream for scan-out, screenshot or bench checking. Sits between the drawer mux and the display/readback logic.

Parameters:
H_RES, 160, pixels per line; x range 0..H_RES-1
V_RES, 120, lines per frame; y range 0..V_RES-1
COLOUR_W, 3, bits per pixel
BG_COLOUR, 3'b000, fill value used by the optional clear

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
x  in  8  write pixel column
y  in  7  write pixel row
colour  in  COLOUR_W  write pixel colour
writeEn  in  1  write strobe; one pixel per cycle while high
wr_drop  out  1  one-cycle pulse: a write was rejected
scan_start  in  1  pulse: begin one full-frame readout
scan_busy  out  1  high from accepted scan_start until the last pixel handshakes
scan_x  out  8  column of the presented pixel
scan_y  out  7  row of the presented pixel
scan_colour  out  COLOUR_W  stored colour
scan_valid  out  1  presented pixel valid
scan_ready  in  1  consumer accepts the pixel
frame_done  out  1  one-cycle pulse after the last pixel (159,119) handshakes

Behaviour:
- Reset (sync, reset_n=0 at a clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE; scan counters and skid buffer are cleared.
  - Memory contents are not altered, except under the optional feature.
- Address: addr = y*H_RES + x, 15 bits, range 0..19199.
- Write path:
  - writeEn=1 with x<H_RES and y<V_RES writes at that edge.
  - writeEn=1 with x>=H_RES or y>=V_RES is not written; wr_drop pulses the next cycle.
  - Writes are accepted in every state, including during a scan, so no drawer ever stalls.
- Memory: one write port and one synchronous read port. Read data appears 1 cycle after the address. A read and write to the same address in the same cycle returns the OLD data.
- Scan FSM:
  - IDLE: scan_start=1 -> SCAN. Address counter = (0,0); scan_busy=1 from the next cycle.
  - SCAN:
    - A read is issued when the skid buffer has a free slot after accounting for the in-flight read.
    - Counter order: x increments; at x=H_RES-1 it wraps to 0 and y increments.
    - After issuing (H_RES-1, V_RES-1) -> DRAIN.
  - DRAIN: wait until the buffer empties and the last pixel has handshaked. Then frame_done=1 for one cycle and go to IDLE; scan_busy falls in that same cycle.
  - scan_start is ignored outside IDLE.
- Stream output:
  - A 2-entry skid buffer absorbs the 1-cycle read latency.
  - A transfer occurs when scan_valid & scan_ready.
  - scan_x, scan_y, scan_colour are held stable while scan_valid=1 and scan_ready=0.
  - With scan_ready held at 1, throughput is 1 pixel/cycle. The first scan_valid comes 2 cycles after scan_start; a full frame takes 19200 + 2 cycles.
- Reset mid-scan: the scan aborts immediately, with no frame_done and scan_valid=0 the next cycle.

Optional Feature:
PIXEL_FRAME_STORE_CLEAR_EN
- Defined:
  - After reset the FSM enters CLEAR and writes BG_COLOUR to addresses 0..19199, one per cycle (19200 cycles).
  - scan_busy=1 during CLEAR; external writes are ignored and do not raise wr_drop.
  - scan_start is ignored during CLEAR; CLEAR then goes to IDLE.
- Undefined: no CLEAR state; reset goes straight to IDLE and memory keeps its prior contents.

Decomposition:
- Package pixel_frame_pkg: H_RES, V_RES, FB_DEPTH (19200), ADDR_W (15), colour_t (COLOUR_W-bit), FSM state encoding (IDLE, SCAN, DRAIN, CLEAR).
- Sub-module pixel_frame_skid: 2-entry valid/ready skid buffer carrying {x, y, colour}.
- Memory stays inline as an inferred RAM.

Test Plan:
- Write (0,0)=3'b101 and (159,119)=3'b011 with the other pixels pre-filled 0, then scan with scan_ready=1 -> first pixel (0,0,101) 2 cycles after scan_start; last pixel (159,119,011); frame_done 19202 cycles after scan_start.
- Write x=160,y=5 and x=10,y=120 -> wr_drop pulses on each, and neither (0,6) nor (10,0) changes.
- Scan with scan_ready toggling 1,0,0,1 -> no pixel lost or duplicated; outputs held during stalls; exactly 19200 transfers in raster order.
- Write (20,0)=3'b111 in the same cycle the scan reads address 20 (old value 000) -> scan shows 000; a second scan shows 111.
- Assert reset_n=0 for 1 cycle at pixel 5000 -> scan_valid=0 and scan_busy=0 the next cycle, no frame_done; a new scan_start reads from (0,0).
- With PIXEL_FRAME_STORE_CLEAR_EN, BG_COLOUR=3'b010 -> after reset, scan_busy is high for 19200 cycles; a subsequent scan returns 010 everywhere; writes issued during CLEAR have no effect.

Source files
------------

// File: rtl/pixel_frame_store_pkg.sv
// pixel_frame_pkg: shared constants, types and helpers for the pixel frame store.
//   H_RES x V_RES frame, COLOUR_W bits per pixel, FB_DEPTH words addressed by
//   an ADDR_W-bit linear raster address (y*H_RES + x).
package pixel_frame_pkg;

  localparam int unsigned H_RES    = 160;
  localparam int unsigned V_RES    = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned FB_DEPTH = H_RES * V_RES;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [X_W-1:0]      xcoord_t;
  typedef logic [Y_W-1:0]      ycoord_t;

  typedef struct packed {
    xcoord_t x;
    ycoord_t y;
    colour_t colour;
  } pixel_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, CLEAR} state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input xcoord_t x, input ycoord_t y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_frame_store_if.sv
// pixel_frame_store_if: pixel-draw write port plus scan-out stream.
//   Write side : x, y, colour, writeEn (drawer -> store), wr_drop (store -> drawer)
//   Scan control: scan_start (in), scan_busy, frame_done (out)
//   Stream     : scan_x, scan_y, scan_colour, scan_valid (out), scan_ready (in)
// master = drawer/consumer side, slave = the frame store.
interface pixel_frame_store_if;
  import pixel_frame_pkg::*;

  xcoord_t x;
  ycoord_t y;
  colour_t colour;
  logic    writeEn;
  logic    wr_drop;
  logic    scan_start;
  logic    scan_busy;
  xcoord_t scan_x;
  ycoord_t scan_y;
  colour_t scan_colour;
  logic    scan_valid;
  logic    scan_ready;
  logic    frame_done;

  modport master (
    output x, y, colour, writeEn, scan_start, scan_ready,
    input  wr_drop, scan_busy, scan_x, scan_y, scan_colour, scan_valid, frame_done
  );

  modport slave (
    input  x, y, colour, writeEn, scan_start, scan_ready,
    output wr_drop, scan_busy, scan_x, scan_y, scan_colour, scan_valid, frame_done
  );

endinterface

// File: rtl/pixel_frame_store_skid.sv
// pixel_frame_skid: 2-entry valid/ready buffer for {x, y, colour}.
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid, in_data   : pushed unconditionally; upstream guarantees a free slot
//   out_valid, out_data : registered head entry, held while out_ready=0
//   out_ready           : consumer accepts head
//   count               : occupancy 0..2, used upstream for read issue
module pixel_frame_skid
  import pixel_frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  pixel_t     in_data,
  output logic       out_valid,
  output pixel_t     out_data,
  input  logic       out_ready,
  output logic [1:0] count
);

  logic   v1;
  pixel_t d1;
  logic   pop;

  assign pop   = out_valid & out_ready;
  assign count = {1'b0, out_valid} + {1'b0, v1};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      v1        <= 1'b0;
      d1        <= '0;
    end else begin
      case ({in_valid, pop})
        2'b11: begin
          if (v1) begin
            out_data <= d1;
            d1       <= in_data;
          end else begin
            out_data <= in_data;
          end
        end
        2'b10: begin
          if (!out_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
          end else begin
            d1 <= in_data;
            v1 <= 1'b1;
          end
        end
        2'b01: begin
          if (v1) begin
            out_data <= d1;
            v1       <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_frame_store.sv
// pixel_frame_store: 160x120x3 frame memory written by the pixel-draw port and
// replayed on scan_start as a raster-ordered valid/ready stream.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : x/y/colour/writeEn/wr_drop write port, scan_start/scan_busy/
//                  frame_done control, scan_x/scan_y/scan_colour/scan_valid/
//                  scan_ready stream
//   BG_COLOUR    : fill colour for the optional post-reset clear
// Build option: define PIXEL_FRAME_STORE_CLEAR_EN to clear the frame to
// BG_COLOUR after every reset (scan_busy high, writes ignored meanwhile).
module pixel_frame_store
  import pixel_frame_pkg::*;
#(
  parameter colour_t BG_COLOUR = '0
)(
  input logic               clk,
  input logic               reset_n,
  pixel_frame_store_if.slave bus
);

  colour_t mem [FB_DEPTH];

  state_t            state;
  xcoord_t           sx;
  ycoord_t           sy;
  logic              rd_valid;
  xcoord_t           rd_x;
  ycoord_t           rd_y;
  colour_t           rd_data;
  logic              busy_q, done_q, drop_q;
  logic [1:0]        skid_cnt;
  logic              skid_valid;
  pixel_t            skid_out;
  logic              pop, can_issue, rd_issue, last_issue;
  logic              in_range, wr_ok, clearing;
  logic [ADDR_W-1:0] clr_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  colour_t           mem_wdata;

  assign pop        = skid_valid & bus.scan_ready;
  // Issue only if the buffer still has room once the in-flight read lands;
  // a pop this cycle frees a slot, which keeps 1 pixel/cycle throughput.
  assign can_issue  = ({1'b0, skid_cnt} + {2'b0, rd_valid}) < (3'd2 + {2'b0, pop});
  assign rd_issue   = ((state == IDLE) && bus.scan_start) || ((state == SCAN) && can_issue);
  assign last_issue = (sx == X_W'(H_RES - 1)) && (sy == Y_W'(V_RES - 1));

  assign in_range = (bus.x < X_W'(H_RES)) && (bus.y < Y_W'(V_RES));
  assign wr_ok    = bus.writeEn && in_range && !clearing;

`ifdef PIXEL_FRAME_STORE_CLEAR_EN
  assign clearing = (state == CLEAR);
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  assign mem_we    = clearing || wr_ok;
  assign mem_waddr = clearing ? clr_addr : pix_addr(bus.x, bus.y);
  assign mem_wdata = clearing ? BG_COLOUR : bus.colour;

  // Nonblocking write and read in one block: same-address read sees old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_issue) rd_data <= mem[pix_addr(sx, sy)];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sx       <= '0;
      sy       <= '0;
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
`ifdef PIXEL_FRAME_STORE_CLEAR_EN
      state    <= CLEAR;
      busy_q   <= 1'b1;
      clr_addr <= '0;
`else
      state    <= IDLE;
      busy_q   <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      drop_q   <= bus.writeEn && !in_range && !clearing;
      rd_valid <= rd_issue;
      if (rd_issue) begin
        rd_x <= sx;
        rd_y <= sy;
        if (sx == X_W'(H_RES - 1)) begin
          sx <= '0;
          sy <= last_issue ? '0 : sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bus.scan_start) begin
            state  <= SCAN;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          if (rd_issue && last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (!rd_valid && ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && pop))) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        CLEAR: begin
`ifdef PIXEL_FRAME_STORE_CLEAR_EN
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            clr_addr <= '0;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

  pixel_frame_skid u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_valid),
    .in_data   ({rd_x, rd_y, rd_data}),
    .out_valid (skid_valid),
    .out_data  (skid_out),
    .out_ready (bus.scan_ready),
    .count     (skid_cnt)
  );

  assign bus.scan_valid  = skid_valid;
  assign bus.scan_x      = skid_out.x;
  assign bus.scan_y      = skid_out.y;
  assign bus.scan_colour = skid_out.colour;
  assign bus.scan_busy   = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.wr_drop     = drop_q;

endmodule

// File: tb/tb_pixel_frame_store.sv
// tb_pixel_frame_store: randomized self-checking bench for pixel_frame_store.
// Keeps a flat colour array indexed by y*H_RES+x as the frame model and checks
// every scanned pixel against raster order.
module tb_pixel_frame_store;
  import pixel_frame_pkg::*;

  localparam int NPIX = 19200;
  localparam colour_t BG = 3'b010;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  colour_t model [NPIX];

  pixel_frame_store_if bus();

  pixel_frame_store #(.BG_COLOUR(BG)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.x = '0; bus.y = '0; bus.colour = '0; bus.writeEn = 1'b0;
    bus.scan_start = 1'b0; bus.scan_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_busy;
`ifdef PIXEL_FRAME_STORE_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    reset_n = 1'b0;
    idle_inputs();
    tick(); tick();
    checks++; if (bus.scan_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.scan_valid); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", bus.wr_drop); end
    checks++; if (bus.scan_busy !== exp_busy) begin errors++; $display("FAIL reset_busy: got %b want %b", bus.scan_busy, exp_busy); end
    checks++;
    if ({bus.scan_x, bus.scan_y, bus.scan_colour} !== '0) begin
      errors++; $display("FAIL reset_stream: got x=%0d y=%0d c=%0d want 0", bus.scan_x, bus.scan_y, bus.scan_colour);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_clear();
    int   cnt;
    logic drop_seen;
    cnt = 0;
    drop_seen = 1'b0;
    while (bus.scan_busy === 1'b1 && cnt < 30000) begin
      cnt++;
      bus.writeEn    = 1'b1;
      bus.x          = 8'($urandom_range(0, 199));
      bus.y          = 7'($urandom_range(0, 127));
      bus.colour     = 3'($urandom);
      bus.scan_start = ($urandom_range(0, 63) == 0);
      tick();
      if (bus.wr_drop === 1'b1) drop_seen = 1'b1;
    end
    idle_inputs();
    checks++; if (cnt != NPIX) begin errors++; $display("FAIL clear_busy_cycles: got %0d want %0d", cnt, NPIX); end
    checks++; if (drop_seen) begin errors++; $display("FAIL clear_drop: got 1 want 0"); end
    tick();
    checks++;
    if (bus.scan_busy !== 1'b0 || bus.scan_valid !== 1'b0) begin
      errors++; $display("FAIL clear_start_ignored: got busy=%b valid=%b want 0 0", bus.scan_busy, bus.scan_valid);
    end
    for (int a = 0; a < NPIX; a++) model[a] = BG;
  endtask

  task automatic test_fill();
    logic    drop_seen;
    colour_t c;
    drop_seen = 1'b0;
    for (int a = 0; a < NPIX; a++) begin
      c = 3'($urandom);
      if (a == 0) c = 3'b101;
      if (a == 20) c = 3'b000;
      if (a == NPIX - 1) c = 3'b011;
      bus.x = 8'(a % 160); bus.y = 7'(a / 160); bus.colour = c; bus.writeEn = 1'b1;
      model[a] = c;
      tick();
      if (bus.wr_drop === 1'b1) drop_seen = 1'b1;
    end
    bus.writeEn = 1'b0;
    checks++; if (drop_seen) begin errors++; $display("FAIL fill_drop: got 1 want 0"); end
  endtask

  task automatic test_write_drop();
    colour_t c;
    bus.writeEn = 1'b1; bus.colour = 3'b111;
    bus.x = 8'd160; bus.y = 7'd5;
    tick();
    checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_x160: got %b want 1", bus.wr_drop); end
    bus.x = 8'd10; bus.y = 7'd120;
    tick();
    checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_y120: got %b want 1", bus.wr_drop); end
    c = 3'($urandom);
    bus.x = 8'd12; bus.y = 7'd3; bus.colour = c;
    model[3 * 160 + 12] = c;
    tick();
    checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL drop_valid_write: got %b want 0", bus.wr_drop); end
    for (int i = 0; i < 4; i++) begin
      bus.x = 8'($urandom_range(160, 255)); bus.y = 7'($urandom_range(0, 127));
      tick();
      checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_rand_x%0d: got %b want 1", i, bus.wr_drop); end
    end
    bus.writeEn = 1'b0;
    tick();
    checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_end: got %b want 0", bus.wr_drop); end
  endtask

  // Full scan with scan_ready=1; a write to (20,0) lands in the cycle address 20 is read.
  task automatic test_scan_full();
    int      k, cyc, first_cyc, done_cyc;
    logic    busy_at_done, valid_at_done, busy_gap;
    colour_t old20, exp;
    old20 = model[20];
    k = 0; first_cyc = 0; done_cyc = 0; busy_gap = 1'b0;
    busy_at_done = 1'b1; valid_at_done = 1'b1;
    bus.scan_ready = 1'b1;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    cyc = 1;
    while (done_cyc == 0 && cyc < NPIX + 100) begin
      if (cyc == 20) begin
        bus.writeEn = 1'b1; bus.x = 8'd20; bus.y = 7'd0; bus.colour = 3'b111;
      end else begin
        bus.writeEn = 1'b0;
      end
      if (bus.frame_done === 1'b1) begin
        done_cyc = cyc; busy_at_done = bus.scan_busy; valid_at_done = bus.scan_valid;
      end else begin
        if (bus.scan_busy !== 1'b1) busy_gap = 1'b1;
        if (bus.scan_valid === 1'b1) begin
          if (first_cyc == 0) first_cyc = cyc;
          exp = (k == 20) ? old20 : model[k];
          checks++;
          if (bus.scan_x !== 8'(k % 160) || bus.scan_y !== 7'(k / 160) || bus.scan_colour !== exp) begin
            errors++;
            $display("FAIL full_pix %0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     k, bus.scan_x, bus.scan_y, bus.scan_colour, k % 160, k / 160, exp);
          end
          k++;
        end
        tick();
        cyc++;
      end
    end
    model[20] = 3'b111;
    bus.writeEn = 1'b0;
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL full_first_latency: got %0d want 2", first_cyc); end
    checks++; if (k != NPIX) begin errors++; $display("FAIL full_count: got %0d want %0d", k, NPIX); end
    checks++; if (done_cyc != NPIX + 2) begin errors++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, NPIX + 2); end
    checks++; if (busy_at_done !== 1'b0 || valid_at_done !== 1'b0) begin
      errors++; $display("FAIL full_busy_at_done: got busy=%b valid=%b want 0 0", busy_at_done, valid_at_done);
    end
    checks++; if (busy_gap) begin errors++; $display("FAIL full_busy_during_scan: got 0 want 1"); end
    tick();
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b want 0", bus.frame_done); end
  endtask

  task automatic test_stall();
    int       k, cyc, done_cyc, last_hs;
    logic     ready, held_pending;
    logic [3:0] pat;
    pixel_t   held;
    pat = 4'b1001;
    k = 0; done_cyc = 0; last_hs = 0; held_pending = 1'b0; held = '0;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    cyc = 1;
    while (done_cyc == 0 && cyc < 4 * NPIX) begin
      if (bus.frame_done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (held_pending) begin
          checks++;
          if (bus.scan_valid !== 1'b1 || {bus.scan_x, bus.scan_y, bus.scan_colour} !== held) begin
            errors++;
            $display("FAIL stall_hold %0d: got v=%b x=%0d y=%0d c=%0d want v=1 x=%0d y=%0d c=%0d",
                     k, bus.scan_valid, bus.scan_x, bus.scan_y, bus.scan_colour, held.x, held.y, held.colour);
          end
          held_pending = 1'b0;
        end
        ready = (k < 10000) ? pat[cyc % 4] : 1'($urandom);
        bus.scan_ready = ready;
        if (bus.scan_valid === 1'b1) begin
          if (ready) begin
            checks++;
            if (bus.scan_x !== 8'(k % 160) || bus.scan_y !== 7'(k / 160) || bus.scan_colour !== model[k]) begin
              errors++;
              $display("FAIL stall_pix %0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                       k, bus.scan_x, bus.scan_y, bus.scan_colour, k % 160, k / 160, model[k]);
            end
            k++;
            last_hs = cyc;
          end else begin
            held = {bus.scan_x, bus.scan_y, bus.scan_colour};
            held_pending = 1'b1;
          end
        end
        tick();
        cyc++;
      end
    end
    bus.scan_ready = 1'b1;
    checks++; if (k != NPIX) begin errors++; $display("FAIL stall_count: got %0d want %0d", k, NPIX); end
    checks++; if (done_cyc == 0 || done_cyc != last_hs + 1) begin
      errors++; $display("FAIL stall_done_timing: got %0d want %0d", done_cyc, last_hs + 1);
    end
    checks++; if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %b want 0", bus.scan_busy); end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int   k, cyc;
    logic done_seen;
    k = 0; cyc = 0; done_seen = 1'b0;
    bus.scan_ready = 1'b1;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    while (k < 5000 && cyc < 6000) begin
      if (bus.scan_valid === 1'b1) k++;
      tick();
      cyc++;
    end
    checks++; if (k != 5000) begin errors++; $display("FAIL abort_reach_5000: got %0d want 5000", k); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (bus.scan_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.scan_valid); end
    checks++; if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.scan_busy); end
    for (int i = 0; i < 6; i++) begin
      if (bus.frame_done === 1'b1 || bus.scan_valid === 1'b1) done_seen = 1'b1;
      tick();
    end
    checks++; if (done_seen) begin errors++; $display("FAIL abort_no_done: got 1 want 0"); end
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    tick();
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (bus.scan_valid !== 1'b1 || bus.scan_x !== 8'(j) || bus.scan_y !== 7'd0 || bus.scan_colour !== model[j]) begin
        errors++;
        $display("FAIL restart_pix %0d: got v=%b x=%0d y=%0d c=%0d want v=1 x=%0d y=0 c=%0d",
                 j, bus.scan_valid, bus.scan_x, bus.scan_y, bus.scan_colour, j, model[j]);
      end
      tick();
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
`ifdef PIXEL_FRAME_STORE_CLEAR_EN
    test_clear();
    test_scan_full();
    test_stall();
`else
    test_fill();
    test_write_drop();
    test_scan_full();
    test_stall();
    test_reset_mid_scan();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
